control_unit: RTL

Multi-cycle control sequencer for the bus-based CPU datapath. It fetches each instruction into IR, decodes the opcode, and steps through per-class micro-sequences. Each step drives the register-select (Gra/Grb/Grc, Rin/Rout, BAout), bus-drive, register-load, ALU-op and memory-strobe controls. Memory accesses use a ready handshake. It halts on the `halt` opcode.

---
 rtl/control_unit_if.sv | 33 +++
 rtl/control_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle.
// master: the sequencer (drives controls, reads IR/CON/mem_done).
// slave:  the datapath side.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON;
  logic        mem_done;

  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic IncPC;
  logic [4:0] ops;
  logic Read, Write;
  logic run;
  logic illegal;

  modport master (
    input  IR, CON, mem_done,
    output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output IncPC, ops, Read, Write, run, illegal
  );

  modport slave (
    output IR, CON, mem_done,
    input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  IncPC, ops, Read, Write, run, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control sequencer for the bus-based CPU datapath.
// Fetches into IR, decodes IR[31:27] and steps T3..T7 per instruction class.
// Optional feature macro: CU_MULDIV_EN enables the mul/div sequence; when
// undefined, mul/div decode as undefined opcodes.
module control_unit (
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [4:0] opcode;
  logic is_ld, is_ldi, is_st, is_rtype, is_itype, is_muldiv;
  logic is_br, is_jr, is_mfhi, is_mflo, is_nop, is_halt, is_illegal;
  logic [4:0] alu_imm;
  logic unused_ir;

  assign opcode    = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];

  // Instruction class decode from the opcode field.
  always_comb begin
    is_ld     = (opcode == 5'd0);
    is_ldi    = (opcode == 5'd1);
    is_st     = (opcode == 5'd2);
    is_rtype  = (opcode >= 5'd3) && (opcode <= 5'd11);
    is_itype  = (opcode >= 5'd12) && (opcode <= 5'd14);
`ifdef CU_MULDIV_EN
    is_muldiv = (opcode == 5'd15) || (opcode == 5'd16);
`else
    is_muldiv = 1'b0;
`endif
    is_br     = (opcode == 5'd19);
    is_jr     = (opcode == 5'd20);
    is_mfhi   = (opcode == 5'd24);
    is_mflo   = (opcode == 5'd25);
    is_nop    = (opcode == 5'd26);
    is_halt   = (opcode == 5'd27);
    is_illegal = !(is_ld | is_ldi | is_st | is_rtype | is_itype | is_muldiv |
                   is_br | is_jr | is_mfhi | is_mflo | is_nop | is_halt);
    case (opcode)
      5'd13:   alu_imm = 5'b00101;
      5'd14:   alu_imm = 5'b00110;
      default: alu_imm = 5'b00011;
    endcase
  end

  // Next-state sequencing, including memory wait holds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = bus.mem_done ? S_T2 : S_T1;
      S_T2:  state_d = S_T3;
      S_T3: begin
        if (is_halt)
          state_d = S_HALT;
        else if (is_jr | is_mfhi | is_mflo | is_nop | is_illegal)
          state_d = S_T0;
        else
          state_d = S_T4;
      end
      S_T4:  state_d = S_T5;
      S_T5:  state_d = (is_ld | is_st | is_muldiv | is_br) ? S_T6 : S_T0;
      S_T6: begin
        if (is_ld)
          state_d = bus.mem_done ? S_T7 : S_T6;
        else if (is_st)
          state_d = S_T7;
        else
          state_d = S_T0;
      end
      S_T7: begin
        if (is_st)
          state_d = bus.mem_done ? S_T0 : S_T7;
        else
          state_d = S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear)
      state_q <= S_RST;
    else
      state_q <= state_d;
  end

  // Control outputs decoded from the registered state and the opcode.
  always_comb begin
    bus.PCout = 1'b0; bus.MDRout = 1'b0; bus.Zhighout = 1'b0; bus.Zlowout = 1'b0;
    bus.HIout = 1'b0; bus.LOout = 1'b0; bus.Cout = 1'b0;
    bus.PCin = 1'b0; bus.IRin = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0;
    bus.Yin = 1'b0; bus.Zin = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0; bus.CONin = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
    bus.BAout = 1'b0; bus.IncPC = 1'b0; bus.ops = '0;
    bus.Read = 1'b0; bus.Write = 1'b0; bus.illegal = 1'b0;
    bus.run = (state_q != S_RST) && (state_q != S_HALT);

    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
        // PC only loads on the cycle the fetch completes.
        bus.PCin = bus.mem_done;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        if (is_ld | is_ldi | is_st | is_itype) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end else if (is_rtype) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_muldiv) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_br) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
        end else if (is_jr) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
        end else if (is_mfhi) begin
          bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_mflo) begin
          bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_illegal) begin
          bus.illegal = 1'b1;
        end
      end
      S_T4: begin
        if (is_ld | is_ldi | is_st | is_itype) begin
          bus.Cout = 1'b1; bus.Zin = 1'b1; bus.ops = alu_imm;
        end else if (is_rtype) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.ops = opcode;
        end else if (is_muldiv) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.ops = opcode;
        end else if (is_br) begin
          bus.PCout = 1'b1; bus.Yin = 1'b1;
        end
      end
      S_T5: begin
        if (is_rtype | is_ldi | is_itype) begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_ld | is_st) begin
          bus.Zlowout = 1'b1; bus.MARin = 1'b1;
        end else if (is_muldiv) begin
          bus.Zlowout = 1'b1; bus.LOin = 1'b1;
        end else if (is_br) begin
          bus.Cout = 1'b1; bus.Zin = 1'b1; bus.ops = 5'b00011;
        end
      end
      S_T6: begin
        if (is_ld) begin
          bus.Read = 1'b1; bus.MDRin = 1'b1;
        end else if (is_st) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
        end else if (is_muldiv) begin
          bus.Zhighout = 1'b1; bus.HIin = 1'b1;
        end else if (is_br) begin
          // Branch target is only driven onto PC when the condition holds.
          bus.Zlowout = bus.CON; bus.PCin = bus.CON;
        end
      end
      S_T7: begin
        if (is_ld) begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_st) begin
          bus.Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
